memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 27 ++
 rtl/latency_timer.sv | 35 +++
 rtl/memory_arbiter.sv | 158 +++++++++++++++
 tb/tb_memory_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_pkg
// Description : Shared types and default constants for the memory arbiter:
//               FSM state encoding, granted-port encoding and the default
//               RAM latency / starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

  localparam int DEFAULT_LATENCY    = 2;
  localparam int DEFAULT_MAX_STARVE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_MEM = 1'b1
  } port_e;

endpackage
`default_nettype wire

// File: rtl/latency_timer.sv
`default_nettype none
// ============================================================================
// Module      : latency_timer
// Description : Down-counter tracking the RAM read latency. Loaded with
//               LATENCY, decremented on request, expires when it reads 1.
// Ports       : clk, reset (async, active-low), load_i, dec_i, expire_o
// Revision    : 1.0 - initial release
// ============================================================================
module latency_timer #(
  parameter int LATENCY = 2,
  localparam int CW = $clog2(LATENCY + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_o
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= CW'(LATENCY);
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign expire_o = (count_q == CW'(1));

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Arbitrates an instruction-fetch read port and a data port
//               onto one single-ported RAM. Data port has priority unless
//               the IF port has been passed over MAX_STARVE times in a row.
// Ports       : clk, reset (async, active-low)
//               ifReq/ifAddress -> ifReady/ifData           (IF read port)
//               memReq/memWrite/memAddress/memWriteData
//                 -> memReady/memReadData                    (data port)
//               ramEnable/ramWrite/ramAddress/ramWriteData, ramReadData
//               stallIf/stallMem                             (pipeline stalls)
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int LATENCY    = DEFAULT_LATENCY,
  parameter int MAX_STARVE = DEFAULT_MAX_STARVE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifReq,
  input  logic [31:0] ifAddress,
  output logic        ifReady,
  output logic [31:0] ifData,
  input  logic        memReq,
  input  logic        memWrite,
  input  logic [31:0] memAddress,
  input  logic [31:0] memWriteData,
  output logic        memReady,
  output logic [31:0] memReadData,
  output logic        ramEnable,
  output logic        ramWrite,
  output logic [31:0] ramAddress,
  output logic [31:0] ramWriteData,
  input  logic [31:0] ramReadData,
  output logic        stallIf,
  output logic        stallMem
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  state_e        state_q;
  port_e         grant_q;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          ramEnable_q;
  logic          ramWrite_q;
  logic [31:0]   ramAddress_q;
  logic [31:0]   ramWriteData_q;
  logic          ifReady_q;
  logic          memReady_q;
  logic [31:0]   ifData_q;
  logic [31:0]   memReadData_q;
  logic          pick_if;
  logic          timer_expire;

  latency_timer #(.LATENCY(LATENCY)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (state_q == ISSUE),
    .dec_i    (state_q == WAIT),
    .expire_o (timer_expire)
  );

  // IF wins when the data port is idle or when IF has starved long enough.
  assign pick_if = ifReq && (!memReq || (starve_q == SW'(MAX_STARVE)));

  // Starvation counter next value; only committed in IDLE.
  always_comb begin
    starve_d = starve_q;
    if (!ifReq) begin
      starve_d = '0;
    end else if (memReq && !pick_if) begin
      if (starve_q != SW'(MAX_STARVE)) begin
        starve_d = starve_q + SW'(1);
      end
    end else begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      grant_q        <= PORT_IF;
      starve_q       <= '0;
      ramEnable_q    <= 1'b0;
      ramWrite_q     <= 1'b0;
      ramAddress_q   <= '0;
      ramWriteData_q <= '0;
      ifReady_q      <= 1'b0;
      memReady_q     <= 1'b0;
      ifData_q       <= '0;
      memReadData_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          starve_q <= starve_d;
          if (ifReq || memReq) begin
            state_q     <= ISSUE;
            ramEnable_q <= 1'b1;
            if (pick_if) begin
              grant_q        <= PORT_IF;
              ramWrite_q     <= 1'b0;
              ramAddress_q   <= ifAddress;
              ramWriteData_q <= '0;
            end else begin
              grant_q        <= PORT_MEM;
              ramWrite_q     <= memWrite;
              ramAddress_q   <= memAddress;
              ramWriteData_q <= memWriteData;
            end
          end
        end
        ISSUE: begin
          ramEnable_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (timer_expire) begin
            state_q <= DONE;
            if (grant_q == PORT_IF) begin
              ifData_q  <= ramReadData;
              ifReady_q <= 1'b1;
            end else begin
              // Writes complete with the same timing but leave read data alone.
              if (!ramWrite_q) begin
                memReadData_q <= ramReadData;
              end
              memReady_q <= 1'b1;
            end
          end
        end
        DONE: begin
          ifReady_q  <= 1'b0;
          memReady_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ramEnable    = ramEnable_q;
  assign ramWrite     = ramWrite_q;
  assign ramAddress   = ramAddress_q;
  assign ramWriteData = ramWriteData_q;
  assign ifReady      = ifReady_q;
  assign memReady     = memReady_q;
  assign ifData       = ifData_q;
  assign memReadData  = memReadData_q;
  assign stallIf      = ifReq && !ifReady_q;
  assign stallMem     = memReq && !memReady_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Directed self-checking bench for memory_arbiter with
//               LATENCY=2, MAX_STARVE=4. A small RAM model returns data two
//               cycles after each ramEnable cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

  logic        clk;
  logic        reset;
  logic        ifReq;
  logic [31:0] ifAddress;
  logic        ifReady;
  logic [31:0] ifData;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memReady;
  logic [31:0] memReadData;
  logic        ramEnable;
  logic        ramWrite;
  logic [31:0] ramAddress;
  logic [31:0] ramWriteData;
  logic [31:0] ramReadData;
  logic        stallIf;
  logic        stallMem;

  int n_tests = 0;
  int n_fail  = 0;

  memory_arbiter #(.LATENCY(2), .MAX_STARVE(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ifReq        (ifReq),
    .ifAddress    (ifAddress),
    .ifReady      (ifReady),
    .ifData       (ifData),
    .memReq       (memReq),
    .memWrite     (memWrite),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memReady     (memReady),
    .memReadData  (memReadData),
    .ramEnable    (ramEnable),
    .ramWrite     (ramWrite),
    .ramAddress   (ramAddress),
    .ramWriteData (ramWriteData),
    .ramReadData  (ramReadData),
    .stallIf      (stallIf),
    .stallMem     (stallMem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: contents are a fixed function of the address; data is valid
  // only in the cycle two cycles after the ramEnable cycle.
  logic        v1, v2;
  logic [31:0] a1, a2;
  initial begin
    v1 = 1'b0; v2 = 1'b0; a1 = '0; a2 = '0;
  end
  always @(posedge clk) begin
    v1 <= ramEnable;
    a1 <= ramAddress;
    v2 <= v1;
    a2 <= a1;
  end

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C22_0004 : (a ^ 32'hA5A5_0000);
  endfunction

  assign ramReadData = v2 ? ram_word(a2) : 32'hBADB_AD00;

  task automatic check_all_zero(input string tag);
    logic [31:0] got [8];
    string       nm  [8];
    got = '{32'(ramEnable), 32'(ramWrite), ramAddress, ramWriteData,
            32'(ifReady), 32'(memReady), ifData, memReadData};
    nm  = '{"ramEnable", "ramWrite", "ramAddress", "ramWriteData",
            "ifReady", "memReady", "ifData", "memReadData"};
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (got[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL %s %s: got %h expected 0", tag, nm[i], got[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ifReq = 1'b0; ifAddress = '0;
    memReq = 1'b0; memWrite = 1'b0; memAddress = '0; memWriteData = '0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_if_read();
    logic e;
    @(posedge clk); #1;
    ifReq = 1'b1; ifAddress = 32'h40;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      e = (k == 1);
      n_tests++;
      if (ramEnable !== e) begin
        n_fail++; $display("FAIL if_read ramEnable c%0d: got %b expected %b", k, ramEnable, e);
      end
      if (k == 1) begin
        n_tests++;
        if (ramAddress !== 32'h40 || ramWrite !== 1'b0) begin
          n_fail++; $display("FAIL if_read issue: got addr %h wr %b expected 40/0", ramAddress, ramWrite);
        end
      end
      e = (k == 4);
      n_tests++;
      if (ifReady !== e) begin
        n_fail++; $display("FAIL if_read ifReady c%0d: got %b expected %b", k, ifReady, e);
      end
      e = (k < 4);
      n_tests++;
      if (stallIf !== e) begin
        n_fail++; $display("FAIL if_read stallIf c%0d: got %b expected %b", k, stallIf, e);
      end
      if (k >= 4) begin
        n_tests++;
        if (ifData !== 32'h8C22_0004) begin
          n_fail++; $display("FAIL if_read ifData c%0d: got %h expected 8c220004", k, ifData);
        end
      end
      if (k == 4) ifReq = 1'b0;
    end
  endtask

  task automatic test_mem_write();
    logic e;
    @(posedge clk); #1;
    memReq = 1'b1; memWrite = 1'b1; memAddress = 32'h100; memWriteData = 32'hDEAD_BEEF;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      e = (k == 1);
      n_tests++;
      if (ramEnable !== e) begin
        n_fail++; $display("FAIL mem_write ramEnable c%0d: got %b expected %b", k, ramEnable, e);
      end
      if (k == 1) begin
        n_tests++;
        if (ramWrite !== 1'b1 || ramWriteData !== 32'hDEAD_BEEF || ramAddress !== 32'h100) begin
          n_fail++;
          $display("FAIL mem_write issue: got wr %b data %h addr %h expected 1/deadbeef/100",
                   ramWrite, ramWriteData, ramAddress);
        end
      end
      e = (k == 4);
      n_tests++;
      if (memReady !== e) begin
        n_fail++; $display("FAIL mem_write memReady c%0d: got %b expected %b", k, memReady, e);
      end
      n_tests++;
      if (memReadData !== 32'h0) begin
        n_fail++; $display("FAIL mem_write memReadData c%0d: got %h expected 0", k, memReadData);
      end
      if (k == 4) begin
        memReq = 1'b0; memWrite = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic e;
    @(posedge clk); #1;
    memReq = 1'b1; memWrite = 1'b0; memAddress = 32'h204;
    ifReq = 1'b1; ifAddress = 32'h80;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      e = (k == 1) || (k == 6);
      n_tests++;
      if (ramEnable !== e) begin
        n_fail++; $display("FAIL simul ramEnable c%0d: got %b expected %b", k, ramEnable, e);
      end
      if (k == 1 || k == 6) begin
        n_tests++;
        if (ramAddress !== ((k == 1) ? 32'h204 : 32'h80)) begin
          n_fail++; $display("FAIL simul ramAddress c%0d: got %h expected %h", k, ramAddress,
                             (k == 1) ? 32'h204 : 32'h80);
        end
      end
      e = (k == 4);
      n_tests++;
      if (memReady !== e) begin
        n_fail++; $display("FAIL simul memReady c%0d: got %b expected %b", k, memReady, e);
      end
      e = (k == 9);
      n_tests++;
      if (ifReady !== e) begin
        n_fail++; $display("FAIL simul ifReady c%0d: got %b expected %b", k, ifReady, e);
      end
      if (k == 4) begin
        n_tests++;
        if (memReadData !== 32'hA5A5_0204) begin
          n_fail++; $display("FAIL simul memReadData: got %h expected a5a50204", memReadData);
        end
        memReq = 1'b0;
      end
      if (k == 9) begin
        n_tests++;
        if (ifData !== 32'hA5A5_0080) begin
          n_fail++; $display("FAIL simul ifData: got %h expected a5a50080", ifData);
        end
        ifReq = 1'b0;
      end
    end
  endtask

  task automatic test_starvation();
    logic [31:0] seen [$];
    logic [31:0] exp_addr [6];
    int          n_mem_rdy;
    int          n_if_rdy;
    exp_addr  = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h44, 32'h300};
    n_mem_rdy = 0;
    n_if_rdy  = 0;
    @(posedge clk); #1;
    memReq = 1'b1; memWrite = 1'b0; memAddress = 32'h300;
    ifReq = 1'b1; ifAddress = 32'h44;
    for (int k = 0; k <= 31; k++) begin
      @(negedge clk);
      if (ramEnable === 1'b1) seen.push_back(ramAddress);
      if (memReady === 1'b1) n_mem_rdy++;
      if (ifReady === 1'b1) n_if_rdy++;
      if (k == 26) begin
        memReq = 1'b0; ifReq = 1'b0;
      end
    end
    n_tests++;
    if (seen.size() != 6) begin
      n_fail++; $display("FAIL starve grant_count: got %0d expected 6", seen.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (i >= seen.size() || seen[i] !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL starve grant%0d: got %h expected %h", i,
                 (i < seen.size()) ? seen[i] : 32'hFFFF_FFFF, exp_addr[i]);
      end
    end
    n_tests++;
    if (n_mem_rdy != 5 || n_if_rdy != 1) begin
      n_fail++; $display("FAIL starve ready_counts: got mem %0d if %0d expected 5/1", n_mem_rdy, n_if_rdy);
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    @(posedge clk); #1;
    ifReq = 1'b1; ifAddress = 32'h40;
    @(negedge clk);  // grant cycle
    @(negedge clk);  // ISSUE
    @(negedge clk);  // WAIT
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (ifReady !== 1'b0 || ramEnable !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid held c%0d: got rdy %b en %b expected 0/0", k, ifReady, ramEnable);
      end
    end
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      e = (k == 1);
      n_tests++;
      if (ramEnable !== e) begin
        n_fail++; $display("FAIL reset_mid ramEnable c%0d: got %b expected %b", k, ramEnable, e);
      end
      if (k == 1) begin
        n_tests++;
        if (ramAddress !== 32'h40) begin
          n_fail++; $display("FAIL reset_mid ramAddress: got %h expected 40", ramAddress);
        end
      end
      e = (k == 4);
      n_tests++;
      if (ifReady !== e) begin
        n_fail++; $display("FAIL reset_mid ifReady c%0d: got %b expected %b", k, ifReady, e);
      end
      if (k == 4) begin
        n_tests++;
        if (ifData !== 32'h8C22_0004) begin
          n_fail++; $display("FAIL reset_mid ifData: got %h expected 8c220004", ifData);
        end
        ifReq = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_mem_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
